// File: rtl/spi_flash_seq_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : spi_flash_pkg                                                    |
// | Brief  : Shared state encoding and flash opcodes for the command sequencer|
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
package spi_flash_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_WREN     = 4'd1,
        ST_PP_CMD   = 4'd2,
        ST_ADDR     = 4'd3,
        ST_WR_DATA  = 4'd4,
        ST_RD_CMD   = 4'd5,
        ST_RD_DATA  = 4'd6,
        ST_POLL_CMD = 4'd7,
        ST_POLL_RD  = 4'd8,
        ST_GAP      = 4'd9,
        ST_DONE     = 4'd10
    } state_t;

    localparam logic [7:0] DEF_CMD_READ = 8'h03;
    localparam logic [7:0] DEF_CMD_PP   = 8'h02;
    localparam logic [7:0] DEF_CMD_WREN = 8'h06;
    localparam logic [7:0] DEF_CMD_RDSR = 8'h05;
    localparam int         WIP_BIT      = 0;

endpackage
`default_nettype wire

// File: rtl/spi_flash_seq_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : spi_flash_seq_if                                                 |
// | Brief  : Word request / response channel of the flash command sequencer   |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
interface spi_flash_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [23:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_flash_seq_byte_issuer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : spi_flash_byte_issuer                                            |
// | Brief  : One-byte-at-a-time start/done handshake and chip-select framing  |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
module spi_flash_byte_issuer (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       issue,
    input  wire logic [7:0] tx_in,
    input  wire logic       last,
    input  wire logic       byte_done,
    output logic            idle,
    output logic            done,
    output logic            byte_start,
    output logic [7:0]      byte_tx,
    output logic            frame
);

    logic pending;

    assign idle = !pending;
    // Stray byte_done pulses are ignored unless a byte is outstanding.
    assign done = pending && byte_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 1'b0;
            byte_start <= 1'b0;
            byte_tx    <= 8'h00;
            frame      <= 1'b0;
        end else begin
            byte_start <= 1'b0;
            if (issue && !pending) begin
                byte_start <= 1'b1;
                byte_tx    <= tx_in;
                frame      <= 1'b1;
                pending    <= 1'b1;
            end else if (done) begin
                pending <= 1'b0;
                // last is evaluated at completion so polling can close on status.
                if (last) begin
                    frame <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_flash_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : spi_flash_seq                                                    |
// | Brief  : Expands word read/write requests into flash command frames       |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
module spi_flash_seq
    import spi_flash_pkg::*;
#(
    parameter logic [7:0] CMD_READ = DEF_CMD_READ,
    parameter logic [7:0] CMD_PP   = DEF_CMD_PP,
    parameter logic [7:0] CMD_WREN = DEF_CMD_WREN,
    parameter logic [7:0] CMD_RDSR = DEF_CMD_RDSR,
    parameter int         CS_GAP   = 4,
    parameter int         POLL_MAX = 65535
) (
    input  wire logic       clk,
    input  wire logic       reset,
    spi_flash_seq_if.slave  bus,
    output logic            busy,
    output logic            byte_start,
    output logic [7:0]      byte_tx,
    input  wire logic       byte_done,
    input  wire logic [7:0] byte_rx,
    output logic            frame
);

    localparam int GAP_W = $clog2(CS_GAP + 1);

    state_t            state, state_n, ret_state, ret_n;
    logic [1:0]        byte_idx, idx_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic [15:0]       poll_cnt, poll_n;
    logic              lat_write;
    logic [23:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       rdata;
    logic              err;

    logic              accept, capture, err_load, err_val;
    logic              issue, last, idle, done, timeout, wip;
    logic [7:0]        tx_sel;

    spi_flash_byte_issuer u_issuer (
        .clk        (clk),
        .reset      (reset),
        .issue      (issue),
        .tx_in      (tx_sel),
        .last       (last),
        .byte_done  (byte_done),
        .idle       (idle),
        .done       (done),
        .byte_start (byte_start),
        .byte_tx    (byte_tx),
        .frame      (frame)
    );

    assign wip     = byte_rx[WIP_BIT];
    // Timeout when this status byte would be the POLL_MAX-th one still busy.
    assign timeout = ({1'b0, poll_cnt} + 17'd1) >= 17'(POLL_MAX);

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_DONE);
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            byte_idx  <= 2'd0;
            gap_cnt   <= '0;
            poll_cnt  <= 16'd0;
            lat_write <= 1'b0;
            lat_addr  <= 24'd0;
            lat_wdata <= 32'd0;
            rdata     <= 32'd0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
            byte_idx  <= idx_n;
            gap_cnt   <= gap_n;
            poll_cnt  <= poll_n;
            if (accept) begin
                lat_write <= bus.req_write;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                rdata     <= 32'd0;
                err       <= 1'b0;
            end
            if (capture) begin
                rdata[{byte_idx, 3'b000} +: 8] <= byte_rx;
            end
            if (err_load) begin
                err <= err_val;
            end
        end
    end

    always_comb begin
        state_n  = state;
        ret_n    = ret_state;
        idx_n    = byte_idx;
        gap_n    = gap_cnt;
        poll_n   = poll_cnt;
        accept   = 1'b0;
        capture  = 1'b0;
        err_load = 1'b0;
        err_val  = 1'b0;
        issue    = 1'b0;
        last     = 1'b0;
        tx_sel   = 8'h00;

        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_n = bus.req_write ? ST_WREN : ST_RD_CMD;
                    idx_n   = 2'd0;
                    gap_n   = '0;
                    poll_n  = 16'd0;
                end
            end
            ST_WREN: begin
                tx_sel = CMD_WREN;
                issue  = idle;
                last   = 1'b1;
                if (done) begin
                    state_n = ST_GAP;
                    ret_n   = ST_PP_CMD;
                end
            end
            ST_PP_CMD, ST_RD_CMD: begin
                tx_sel = (state == ST_PP_CMD) ? CMD_PP : CMD_READ;
                issue  = idle;
                if (done) begin
                    state_n = ST_ADDR;
                    idx_n   = 2'd0;
                end
            end
            ST_ADDR: begin
                case (byte_idx)
                    2'd0:    tx_sel = lat_addr[23:16];
                    2'd1:    tx_sel = lat_addr[15:8];
                    default: tx_sel = lat_addr[7:0];
                endcase
                issue = idle;
                if (done) begin
                    if (byte_idx == 2'd2) begin
                        idx_n   = 2'd0;
                        state_n = lat_write ? ST_WR_DATA : ST_RD_DATA;
                    end else begin
                        idx_n = byte_idx + 2'd1;
                    end
                end
            end
            ST_WR_DATA: begin
                tx_sel = lat_wdata[{byte_idx, 3'b000} +: 8];
                issue  = idle;
                last   = (byte_idx == 2'd3);
                if (done) begin
                    idx_n = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_n = ST_GAP;
                        ret_n   = ST_POLL_CMD;
                    end
                end
            end
            ST_RD_DATA: begin
                issue = idle;
                last  = (byte_idx == 2'd3);
                if (done) begin
                    capture = 1'b1;
                    idx_n   = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_POLL_CMD: begin
                tx_sel = CMD_RDSR;
                issue  = idle;
                if (done) begin
                    state_n = ST_POLL_RD;
                end
            end
            ST_POLL_RD: begin
                issue = idle;
                last  = !wip || timeout;
                if (done) begin
                    if (!wip || timeout) begin
                        state_n  = ST_DONE;
                        err_load = 1'b1;
                        err_val  = wip;
                    end
                    if (poll_cnt != 16'hFFFF) begin
                        poll_n = poll_cnt + 16'd1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
                    gap_n   = '0;
                    state_n = ret_state;
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : tb_spi_flash_seq                                                 |
// | Brief  : Self-checking bench with flash engine model and frame reference  |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_spi_flash_seq;

    localparam int CS_GAP   = 4;
    localparam int POLL_MAX = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy, byte_start, byte_done, frame;
    logic [7:0] byte_tx, byte_rx;

    spi_flash_seq_if bus();

    spi_flash_seq #(.CS_GAP(CS_GAP), .POLL_MAX(POLL_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .byte_start (byte_start),
        .byte_tx    (byte_tx),
        .byte_done  (byte_done),
        .byte_rx    (byte_rx),
        .frame      (frame)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    int         txq[$];
    int         expq[$];
    logic [7:0] rdq[$];
    logic [7:0] stq[$];
    int         lat_cfg   = 1;
    int         rsp_count = 0;
    int         n_txn     = 0;
    int         fpos      = 0;
    logic [7:0] fcmd      = 8'h00;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flash engine: one byte at a time, configurable latency, frame-aware replies.
    initial begin
        logic [7:0] cur_tx, cur_rx;
        int         wait_left;
        logic       eng_busy, prev_frame;
        byte_done = 1'b0; byte_rx = 8'h00;
        cur_tx = 8'h00; cur_rx = 8'h00; wait_left = 0; eng_busy = 1'b0; prev_frame = 1'b0;
        forever begin
            @(posedge clk); #1;
            byte_done = 1'b0;
            if (reset) begin
                eng_busy   = 1'b0;
                prev_frame = 1'b0;
            end else begin
                if (byte_start) begin
                    check32("start_while_busy", {31'b0, eng_busy}, 32'd0);
                    check32("frame_with_start", {31'b0, frame}, 32'd1);
                    if (!prev_frame) begin
                        txq.push_back(-1);
                        fpos = 0;
                        fcmd = byte_tx;
                    end
                    txq.push_back(int'(byte_tx));
                    cur_tx = byte_tx;
                    if (fcmd == 8'h03 && fpos >= 4 && rdq.size() > 0) cur_rx = rdq.pop_front();
                    else if (fcmd == 8'h05 && fpos >= 1 && stq.size() > 0) cur_rx = stq.pop_front();
                    else cur_rx = 8'($urandom);
                    fpos++;
                    eng_busy  = 1'b1;
                    wait_left = (lat_cfg < 0) ? int'($urandom_range(3, 0)) : lat_cfg;
                end else if (eng_busy) begin
                    check32("tx_stable", {24'd0, byte_tx}, {24'd0, cur_tx});
                end
                if (eng_busy) begin
                    if (wait_left == 0) begin
                        byte_done = 1'b1;
                        byte_rx   = cur_rx;
                        eng_busy  = 1'b0;
                    end else begin
                        wait_left--;
                    end
                end
                prev_frame = frame;
            end
        end
    end

    // Cycle monitor: frame closing, inter-frame gap, busy/ready coherence, response count.
    initial begin
        logic prev_f, prev_done, prev_rst, had;
        int   low;
        prev_f = 1'b0; prev_done = 1'b0; prev_rst = 1'b1; had = 1'b0; low = 0;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) rsp_count++;
            if (!reset && !prev_rst) begin
                if (prev_f && !frame) check32("frame_fall_after_done", {31'b0, prev_done}, 32'd1);
                if (!prev_f && frame) begin
                    if (had) check32("gap_len", {31'b0, (low >= CS_GAP)}, 32'd1);
                    had = 1'b1;
                    low = 0;
                end else if (!frame) begin
                    low++;
                end
                check32("busy_vs_ready", {31'b0, busy}, {31'b0, !bus.req_ready});
            end
            if (!busy) had = 1'b0;
            prev_f = frame; prev_done = byte_done; prev_rst = reset;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic push_read_exp(input logic [23:0] a);
        expq.push_back(-1); expq.push_back(32'h03);
        expq.push_back(int'(a[23:16])); expq.push_back(int'(a[15:8])); expq.push_back(int'(a[7:0]));
        for (int i = 0; i < 4; i++) expq.push_back(0);
    endtask

    task automatic send_req(input logic wr, input logic [23:0] a, input logic [31:0] d);
        int n;
        n = 0;
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
        while (!bus.req_ready && n < 2000) begin @(posedge clk); #1; n++; end
        check32("accept_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        n_txn++;
    endtask

    task automatic wait_rsp(input logic [31:0] exp_rd, input logic exp_err);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 5000) begin @(posedge clk); #1; n++; end
        check32("rsp_seen", {31'b0, bus.rsp_valid}, 32'd1);
        check32("rsp_rdata", bus.rsp_rdata, exp_rd);
        check32("rsp_err", {31'b0, bus.rsp_err}, {31'b0, exp_err});
        @(posedge clk); #1;
        check32("rsp_single_pulse", {31'b0, bus.rsp_valid}, 32'd0);
        check32("ready_after_rsp", {31'b0, bus.req_ready}, 32'd1);
    endtask

    task automatic compare_frames(input string tag);
        int n;
        check32({tag, "_len"}, txq.size(), expq.size());
        n = (txq.size() < expq.size()) ? txq.size() : expq.size();
        for (int i = 0; i < n; i++) check32(tag, txq[i], expq[i]);
        txq.delete(); expq.delete();
    endtask

    task automatic do_read(input logic [23:0] a, input logic [31:0] rd);
        for (int i = 0; i < 4; i++) rdq.push_back(rd[8*i +: 8]);
        push_read_exp(a);
        send_req(1'b0, a, $urandom);
        bus.req_valid = 1'b0;
        wait_rsp(rd, 1'b0);
        compare_frames("read_frames");
    endtask

    // k = status bytes until WIP clears; k > POLL_MAX means the flash never clears WIP.
    task automatic do_write(input logic [23:0] a, input logic [31:0] d, input int k);
        int nst;
        nst = (k > POLL_MAX) ? POLL_MAX : k;
        for (int i = 0; i < nst; i++)
            stq.push_back((i == k - 1) ? {7'($urandom), 1'b0} : {7'($urandom), 1'b1});
        expq.push_back(-1); expq.push_back(32'h06);
        expq.push_back(-1); expq.push_back(32'h02);
        expq.push_back(int'(a[23:16])); expq.push_back(int'(a[15:8])); expq.push_back(int'(a[7:0]));
        for (int i = 0; i < 4; i++) expq.push_back(int'(d[8*i +: 8]));
        expq.push_back(-1); expq.push_back(32'h05);
        for (int i = 0; i < nst; i++) expq.push_back(0);
        send_req(1'b1, a, d);
        bus.req_valid = 1'b0;
        wait_rsp(32'd0, k > POLL_MAX);
        compare_frames("write_frames");
        check32("status_consumed", stq.size(), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = 24'd0; bus.req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check32("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check32("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        check32("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check32("rst_busy", {31'b0, busy}, 32'd0);
        check32("rst_byte_start", {31'b0, byte_start}, 32'd0);
        check32("rst_byte_tx", {24'd0, byte_tx}, 32'd0);
        check32("rst_frame", {31'b0, frame}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        lat_cfg = 1;
        do_read(24'h123456, 32'h44332211);
        do_write(24'h000100, 32'hDEADBEEF, 3);
        do_write(24'hABCDEF, 32'h01234567, POLL_MAX + 1);

        // Back-to-back reads with req_valid held high throughout.
        for (int i = 0; i < 4; i++) rdq.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) rdq.push_back(8'hB0 + 8'(i));
        push_read_exp(24'h0000F0);
        push_read_exp(24'hFFFF0F);
        send_req(1'b0, 24'h0000F0, 32'd0);
        bus.req_addr = 24'hFFFF0F;
        wait_rsp(32'hA3A2A1A0, 1'b0);
        @(posedge clk); #1;
        check32("b2b_accept", {31'b0, busy}, 32'd1);
        n_txn++;
        bus.req_valid = 1'b0;
        wait_rsp(32'hB3B2B1B0, 1'b0);
        compare_frames("b2b_frames");

        lat_cfg = 20;
        do_read(24'h5A5A5A, 32'hCAFEF00D);
        lat_cfg = 0;
        do_write(24'h00FF00, 32'h13579BDF, 1);

        // Reset in the middle of the page-program frame.
        lat_cfg = 2;
        for (int i = 0; i < 2; i++) stq.push_back(8'h00);
        send_req(1'b1, 24'h777777, 32'h88888888);
        bus.req_valid = 1'b0;
        n = 0;
        while (!(fcmd == 8'h02 && fpos == 2) && n < 500) begin @(posedge clk); #1; n++; end
        check32("reached_pp", {31'b0, (n < 500)}, 32'd1);
        #3 reset = 1'b1;
        #1;
        check32("mid_rst_frame", {31'b0, frame}, 32'd0);
        check32("mid_rst_start", {31'b0, byte_start}, 32'd0);
        check32("mid_rst_busy", {31'b0, busy}, 32'd0);
        n_txn--;
        @(posedge clk); #1;
        txq.delete(); expq.delete(); stq.delete(); rdq.delete();
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        check32("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
        lat_cfg = 1;
        do_read(24'h010203, 32'h0BADF00D);

        lat_cfg = -1;
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(24'($urandom), $urandom, int'($urandom_range(POLL_MAX + 1, 1)));
            else
                do_read(24'($urandom), $urandom);
        end

        repeat (2) @(posedge clk);
        #1;
        check32("rsp_count", rsp_count, n_txn);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
